// File: rtl/csa_accum.sv
// Streaming carry-save accumulator: two chained 3:2 stages per beat keep a
// redundant (S, C) pair; one registered carry-propagate add resolves the group.
module csa_accum #(
  parameter int unsigned N      = 32,
  parameter int unsigned G      = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CW     = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            in_cin,
  input  logic            in_first,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N+G-1:0]  out_sum,
  output logic [CW-1:0]   out_beats
);

  localparam int unsigned W   = N + G;
  localparam logic        SGN = (SIGNED != 0);

  typedef enum logic [1:0] {ST_ACC, ST_CPA, ST_OUT} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d, beats_q, beats_d;
  logic           rdy_q, rdy_d, vld_q, vld_d;

  logic [W-1:0]   ext_a, ext_b, sb, cb, s1, c1;
  logic [W-2:0]   m1, m2;
  logic [CW-1:0]  cntb;
  logic           accept;

  // Abort blocks acceptance in the cycle it is asserted.
  assign in_ready  = rdy_q & ~abort;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_beats = beats_q;

  // 4:2 compression of the base pair with both operands and the carry-in.
  always_comb begin
    ext_a = {{G{SGN & in_a[N-1]}}, in_a};
    ext_b = {{G{SGN & in_b[N-1]}}, in_b};
    sb    = in_first ? '0 : s_q;
    cb    = in_first ? '0 : c_q;
    cntb  = in_first ? '0 : cnt_q;
    s1    = sb ^ cb ^ ext_a;
    m1    = (sb[W-2:0] & cb[W-2:0]) | (sb[W-2:0] & ext_a[W-2:0]) |
            (cb[W-2:0] & ext_a[W-2:0]);
    c1    = {m1, in_cin};
    m2    = (s1[W-2:0] & c1[W-2:0]) | (s1[W-2:0] & ext_b[W-2:0]) |
            (c1[W-2:0] & ext_b[W-2:0]);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    beats_d = beats_q;
    if (abort) begin
      state_d = ST_ACC;
      s_d     = '0;
      c_d     = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (accept) begin
            s_d   = s1 ^ c1 ^ ext_b;
            c_d   = {m2, 1'b0};
            cnt_d = (cntb == '1) ? cntb : cntb + CW'(1);
            if (in_last) state_d = ST_CPA;
          end
        end
        ST_CPA: begin
          sum_d   = s_q + c_q;
          beats_d = cnt_q;
          state_d = ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            state_d = ST_ACC;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
    rdy_d = (state_d == ST_ACC);
    vld_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      beats_q <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      beats_q <= beats_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum: vector table plus hand sequences for
// backpressure, abort, async reset, wrap/saturation and signed extension.
module tb_csa_accum;

  logic        clk, reset_n, abort;
  logic        in_valid, in_ready, in_cin, in_first, in_last;
  logic [7:0]  in_a, in_b;
  logic        out_valid, out_ready;
  logic [11:0] out_sum;
  logic [3:0]  out_beats;

  logic        s_in_valid, s_in_ready, s_in_first, s_in_last, s_out_valid, s_out_ready;
  logic [7:0]  s_in_a, s_in_b;
  logic [11:0] s_out_sum;
  logic [3:0]  s_out_beats;

  csa_accum #(.N(8), .G(4), .SIGNED(0), .CW(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats)
  );

  csa_accum #(.N(8), .G(4), .SIGNED(1), .CW(4)) u_sgn (
    .clk(clk), .reset_n(reset_n), .abort(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_cin(1'b0), .in_first(s_in_first), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_beats(s_out_beats)
  );

  typedef struct {
    logic [7:0]  a, b;
    logic        cin, first, last;
    logic [11:0] sum;
    logic [3:0]  beats;
  } vec_t;

  typedef struct {
    logic [11:0] sum;
    logic [3:0]  beats;
  } exp_t;

  vec_t tbl [10];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  // Starts just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic f, input logic l);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_first = f; in_last = l;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout_fail("beat_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
    if (!ok) timeout_fail("out_valid_wait");
  endtask

  // Holds off the consumer for 'hold' cycles, then pops the scoreboard on handshake.
  task automatic collect(input int hold);
    logic ok;
    exp_t e;
    out_ready = 1'b0;
    wait_valid(ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      timeout_fail("scoreboard_empty");
      return;
    end
    e = exp_q[0];
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(e.sum));
      check("hold_beats", 32'(out_beats), 32'(e.beats));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    check("res_valid", 32'(out_valid), 32'd1);
    check("res_sum", 32'(out_sum), 32'(e.sum));
    check("res_beats", 32'(out_beats), 32'(e.beats));
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic ok;
    int   n;
    tbl[0] = '{8'd3,   8'd5,   1'b0, 1'b1, 1'b0, 12'd0,   4'd0};
    tbl[1] = '{8'd10,  8'd20,  1'b1, 1'b0, 1'b1, 12'd39,  4'd2};
    tbl[2] = '{8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 12'd511, 4'd1};
    tbl[3] = '{8'd100, 8'd0,   1'b0, 1'b1, 1'b0, 12'd0,   4'd0};
    tbl[4] = '{8'd0,   8'd100, 1'b0, 1'b0, 1'b0, 12'd0,   4'd0};
    tbl[5] = '{8'd7,   8'd8,   1'b1, 1'b0, 1'b1, 12'd216, 4'd3};
    tbl[6] = '{8'd1,   8'd2,   1'b0, 1'b0, 1'b1, 12'd3,   4'd1};
    tbl[7] = '{8'd50,  8'd50,  1'b0, 1'b1, 1'b0, 12'd0,   4'd0};
    tbl[8] = '{8'd9,   8'd9,   1'b0, 1'b1, 1'b1, 12'd18,  4'd1};
    tbl[9] = '{8'd255, 8'd254, 1'b0, 1'b1, 1'b1, 12'd509, 4'd1};

    reset_n = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_first = 1'b0; in_last = 1'b0;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_first = 1'b0; s_in_last = 1'b0;
    s_out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Signed instance: -1 + -2 sign-extends to 12 bits.
    s_in_a = 8'hFF; s_in_b = 8'hFE; s_in_first = 1'b1; s_in_last = 1'b1; s_in_valid = 1'b1;
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_out_valid) timeout_fail("signed_valid");
    else begin
      check("signed_sum", 32'(s_out_sum), 32'hFFD);
      check("signed_beats", 32'(s_out_beats), 32'd1);
    end
    @(posedge clk);
    #1;

    // Table-driven groups; the first group also checks the CPA cycle.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].last) exp_q.push_back('{tbl[i].sum, tbl[i].beats});
      send_beat(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].first, tbl[i].last);
      if (i == 1) begin
        @(negedge clk);
        check("cpa_valid_low", 32'(out_valid), 32'd0);
        check("cpa_in_ready_low", 32'(in_ready), 32'd0);
      end
      if (tbl[i].last) collect(0);
    end

    // Backpressure: result held for five cycles, then in_ready returns.
    exp_q.push_back('{12'd8, 4'd1});
    send_beat(8'd4, 8'd4, 1'b0, 1'b1, 1'b1);
    collect(5);
    @(negedge clk);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Abort mid-group: the beat presented with abort is dropped, state clears.
    send_beat(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
    send_beat(8'd2, 8'd2, 1'b0, 1'b0, 1'b0);
    send_beat(8'd3, 8'd3, 1'b0, 1'b0, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_a = 8'd100; in_b = 8'd100; in_last = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("abort_no_result", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back('{12'd11, 4'd1});
    send_beat(8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
    collect(0);
    exp_q.push_back('{12'd2, 4'd1});
    send_beat(8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
    collect(0);

    // Abort while holding a result: result discarded, outputs keep values.
    send_beat(8'd7, 8'd7, 1'b0, 1'b1, 1'b1);
    wait_valid(ok);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_in_ready", 32'(in_ready), 32'd1);
    check("abort_keep_sum", 32'(out_sum), 32'd14);
    check("abort_keep_beats", 32'(out_beats), 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset during CPA.
    send_beat(8'd9, 8'd9, 1'b0, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(out_sum), 32'd0);
    check("async_rst_beats", 32'(out_beats), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{12'd6, 4'd1});
    send_beat(8'd2, 8'd3, 1'b1, 1'b1, 1'b1);
    collect(0);

    // Wrap mod 2^12 and beat-count saturation at 15.
    exp_q.push_back('{12'd495, 4'd15});
    for (int i = 0; i < 17; i++) send_beat(8'd255, 8'd255, 1'b1, i == 0, i == 16);
    collect(0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
